receive_slot_scheduler: RTL and testbench

- Owns the receive queue slots fed by the Ethernet packet parser.
- Picks the slot the parser writes next, via one-hot receive_slot_enable.
- Tracks each slot's life: FREE -> FILLING -> READY -> IN_SERVICE -> FREE.
- Presents completed good packets to the forwarding logic in completion order over a valid/accept handshake, and reclaims slots on release or on a bad CRC.

---
 rtl/receive_slot_scheduler.sv | 170 +++++++++++++++++
 tb/tb_receive_slot_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receive_slot_scheduler.sv
// Receive queue slot scheduler: hands free slots to the packet parser,
// tracks each slot's life, and queues completed good packets downstream.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   packet_data_valid     per-slot byte strobe from the parser
//   good_packet           per-slot CRC-pass pulse
//   bad_packet            per-slot CRC-fail pulse
//   receive_slot_enable   one-hot slot offered to the parser (0 = none free)
//   ready_valid           a READY slot is offered downstream
//   ready_slot            index of the offered slot
//   ready_accept          downstream takes the offered slot
//   release_valid         downstream finished with a slot
//   release_slot          slot being released
//   release_error         pulse on a release of a slot not IN_SERVICE
//   free_slot_count       number of FREE slots
//   good_packet_count     good packets received (wraps)
//   bad_packet_count      bad packets received (wraps)
module receive_slot_scheduler #(
    parameter int RECEIVE_QUE_SLOTS = 4,
    parameter int SLOT_INDEX_WIDTH  = $clog2(RECEIVE_QUE_SLOTS)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [RECEIVE_QUE_SLOTS-1:0]  packet_data_valid,
    input  logic [RECEIVE_QUE_SLOTS-1:0]  good_packet,
    input  logic [RECEIVE_QUE_SLOTS-1:0]  bad_packet,
    output logic [RECEIVE_QUE_SLOTS-1:0]  receive_slot_enable,
    output logic                          ready_valid,
    output logic [SLOT_INDEX_WIDTH-1:0]   ready_slot,
    input  logic                          ready_accept,
    input  logic                          release_valid,
    input  logic [SLOT_INDEX_WIDTH-1:0]   release_slot,
    output logic                          release_error,
    output logic [SLOT_INDEX_WIDTH:0]     free_slot_count,
    output logic [15:0]                   good_packet_count,
    output logic [15:0]                   bad_packet_count
);

    localparam int N  = RECEIVE_QUE_SLOTS;
    localparam int CW = SLOT_INDEX_WIDTH + 1;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_FILLING,
        SLOT_READY,
        SLOT_IN_SERVICE
    } slot_state_t;

    slot_state_t                 state_q [N];
    slot_state_t                 state_n [N];
    logic [SLOT_INDEX_WIDTH-1:0] fifo_q  [N];
    logic [SLOT_INDEX_WIDTH-1:0] fifo_n  [N];
    logic [CW-1:0]               fifo_count_q;
    logic [CW-1:0]               fifo_count_n;

    logic [CW-1:0] good_inc;
    logic [CW-1:0] bad_inc;
    logic [CW-1:0] free_n;
    logic [N-1:0]  enable_n;
    logic          release_hit;
    logic          release_error_n;
    logic          offer_found;

    always_comb begin
        state_n      = state_q;
        fifo_n       = fifo_q;
        fifo_count_n = fifo_count_q;
        good_inc     = '0;
        bad_inc      = '0;
        release_hit  = 1'b0;

        // Pop uses the pre-cycle FIFO so a same-cycle push is never bypassed.
        if (fifo_count_q != '0 && ready_accept) begin
            state_n[fifo_q[0]] = SLOT_IN_SERVICE;
            for (int i = 0; i < N - 1; i++) begin
                fifo_n[i] = fifo_q[i + 1];
            end
            fifo_n[N-1]  = '0;
            fifo_count_n = fifo_count_q - CW'(1);
        end

        for (int k = 0; k < N; k++) begin
            if (release_valid
                && release_slot == SLOT_INDEX_WIDTH'(k)
                && state_q[k] == SLOT_IN_SERVICE) begin
                release_hit = 1'b1;
                state_n[k]  = SLOT_FREE;
            end
        end
        release_error_n = release_valid && !release_hit;

        // Simultaneous completions enter the FIFO in ascending slot order.
        for (int k = 0; k < N; k++) begin
            unique case (state_q[k])
                SLOT_FREE: begin
                    if (packet_data_valid[k]) begin
                        state_n[k] = SLOT_FILLING;
                    end
                end
                SLOT_FILLING: begin
                    if (good_packet[k]) begin
                        state_n[k] = SLOT_READY;
                        fifo_n[fifo_count_n[SLOT_INDEX_WIDTH-1:0]] =
                            SLOT_INDEX_WIDTH'(k);
                        fifo_count_n = fifo_count_n + CW'(1);
                        good_inc     = good_inc + CW'(1);
                    end else if (bad_packet[k]) begin
                        state_n[k] = SLOT_FREE;
                        bad_inc    = bad_inc + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        free_n = '0;
        for (int k = 0; k < N; k++) begin
            if (state_n[k] == SLOT_FREE) begin
                free_n = free_n + CW'(1);
            end
        end

        // A slot mid-packet keeps the offer; otherwise lowest free slot.
        enable_n    = '0;
        offer_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!offer_found && state_n[k] == SLOT_FILLING) begin
                enable_n[k] = 1'b1;
                offer_found = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!offer_found && state_n[k] == SLOT_FREE) begin
                enable_n[k] = 1'b1;
                offer_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                state_q[k] <= SLOT_FREE;
                fifo_q[k]  <= '0;
            end
            fifo_count_q        <= '0;
            receive_slot_enable <= '0;
            ready_valid         <= 1'b0;
            ready_slot          <= '0;
            release_error       <= 1'b0;
            free_slot_count     <= CW'(N);
            good_packet_count   <= '0;
            bad_packet_count    <= '0;
        end else begin
            state_q             <= state_n;
            fifo_q              <= fifo_n;
            fifo_count_q        <= fifo_count_n;
            receive_slot_enable <= enable_n;
            ready_valid         <= fifo_count_n != '0;
            ready_slot          <= (fifo_count_n != '0) ? fifo_n[0] : '0;
            release_error       <= release_error_n;
            free_slot_count     <= free_n;
            good_packet_count   <= good_packet_count + 16'(good_inc);
            bad_packet_count    <= bad_packet_count + 16'(bad_inc);
        end
    end

endmodule

// File: tb/tb_receive_slot_scheduler.sv
// Testbench for receive_slot_scheduler: directed scenarios plus random
// traffic, all checked every cycle against a queue-based slot model.
module tb_receive_slot_scheduler;

    localparam int N = 4;
    localparam int W = 2;

    localparam int S_FREE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_READY = 2;
    localparam int S_SERV  = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [N-1:0]  packet_data_valid;
    logic [N-1:0]  good_packet;
    logic [N-1:0]  bad_packet;
    logic [N-1:0]  receive_slot_enable;
    logic          ready_valid;
    logic [W-1:0]  ready_slot;
    logic          ready_accept;
    logic          release_valid;
    logic [W-1:0]  release_slot;
    logic          release_error;
    logic [W:0]    free_slot_count;
    logic [15:0]   good_packet_count;
    logic [15:0]   bad_packet_count;

    always #5 clock = ~clock;

    receive_slot_scheduler #(.RECEIVE_QUE_SLOTS(N)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .packet_data_valid   (packet_data_valid),
        .good_packet         (good_packet),
        .bad_packet          (bad_packet),
        .receive_slot_enable (receive_slot_enable),
        .ready_valid         (ready_valid),
        .ready_slot          (ready_slot),
        .ready_accept        (ready_accept),
        .release_valid       (release_valid),
        .release_slot        (release_slot),
        .release_error       (release_error),
        .free_slot_count     (free_slot_count),
        .good_packet_count   (good_packet_count),
        .bad_packet_count    (bad_packet_count)
    );

    // Model: slot life states, completion queue, expected outputs.
    int           st [N];
    int           q [$];
    logic [15:0]  gc;
    logic [15:0]  bc;
    logic [N-1:0] e_en;
    logic         e_rv;
    logic [W-1:0] e_rs;
    logic         e_err;
    int           e_free;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) st[k] = S_FREE;
        q.delete();
        gc = 0;
        bc = 0;
        e_en = '0;
        e_rv = 0;
        e_rs = '0;
        e_err = 0;
        e_free = N;
    endfunction

    function automatic void model_step();
        int  ns [N];
        int  rs;
        int  h;
        bit  err;
        bit  done;
        rs  = int'(release_slot);
        err = release_valid && !(rs < N && st[rs] == S_SERV);
        ns  = st;
        if (q.size() > 0 && ready_accept) begin
            h = q.pop_front();
            ns[h] = S_SERV;
        end
        if (release_valid && !err) ns[rs] = S_FREE;
        for (int k = 0; k < N; k++) begin
            if (st[k] == S_FREE && packet_data_valid[k]) begin
                ns[k] = S_FILL;
            end else if (st[k] == S_FILL && good_packet[k]) begin
                ns[k] = S_READY;
                q.push_back(k);
                gc = gc + 16'd1;
            end else if (st[k] == S_FILL && bad_packet[k]) begin
                ns[k] = S_FREE;
                bc = bc + 16'd1;
            end
        end
        st = ns;
        e_err  = err;
        e_rv   = q.size() > 0;
        e_rs   = e_rv ? W'(q[0]) : '0;
        e_free = 0;
        for (int k = 0; k < N; k++) if (st[k] == S_FREE) e_free++;
        e_en = '0;
        done = 0;
        for (int k = 0; k < N; k++)
            if (!done && st[k] == S_FILL) begin e_en[k] = 1; done = 1; end
        for (int k = 0; k < N; k++)
            if (!done && st[k] == S_FREE) begin e_en[k] = 1; done = 1; end
    endfunction

    task automatic check_outputs();
        chk("enable", 32'(receive_slot_enable), 32'(e_en));
        chk("ready_valid", 32'(ready_valid), 32'(e_rv));
        chk("ready_slot", 32'(ready_slot), 32'(e_rs));
        chk("release_error", 32'(release_error), 32'(e_err));
        chk("free_count", 32'(free_slot_count), 32'(e_free));
        chk("good_count", 32'(good_packet_count), 32'(gc));
        chk("bad_count", 32'(bad_packet_count), 32'(bc));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic clear_inputs();
        packet_data_valid = '0;
        good_packet = '0;
        bad_packet = '0;
        ready_accept = 0;
        release_valid = 0;
        release_slot = '0;
    endtask

    task automatic fill(int k, int len);
        packet_data_valid = '0;
        packet_data_valid[k] = 1'b1;
        repeat (len) step();
        packet_data_valid = '0;
    endtask

    task automatic good(int k);
        good_packet[k] = 1'b1;
        step();
        good_packet = '0;
    endtask

    task automatic bad(int k);
        bad_packet[k] = 1'b1;
        step();
        bad_packet = '0;
    endtask

    task automatic accept();
        ready_accept = 1;
        step();
        ready_accept = 0;
    endtask

    task automatic rel(int k);
        release_valid = 1;
        release_slot = W'(k);
        step();
        release_valid = 0;
    endtask

    initial begin
        int serv [$];
        clear_inputs();
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs();
        chk("reset_free_lit", 32'(free_slot_count), 32'd4);
        reset_n = 1;
        step();
        chk("cold_enable_lit", 32'(receive_slot_enable), 32'h1);

        // Cold start: one good packet into slot 0.
        fill(0, 64);
        good(0);
        chk("cold_rv_lit", 32'(ready_valid), 32'd1);
        chk("cold_rs_lit", 32'(ready_slot), 32'd0);
        chk("cold_en_lit", 32'(receive_slot_enable), 32'h2);
        chk("cold_free_lit", 32'(free_slot_count), 32'd3);
        chk("cold_gc_lit", 32'(good_packet_count), 32'd1);
        accept();
        rel(0);

        // Bad CRC reclaims the slot.
        fill(0, 8);
        bad(0);
        chk("bad_rv_lit", 32'(ready_valid), 32'd0);
        chk("bad_en_lit", 32'(receive_slot_enable), 32'h1);
        chk("bad_free_lit", 32'(free_slot_count), 32'd4);
        chk("bad_bc_lit", 32'(bad_packet_count), 32'd1);

        // Exhaustion.
        for (int k = 0; k < N; k++) begin
            fill(k, 4);
            good(k);
        end
        chk("exh_en_lit", 32'(receive_slot_enable), 32'h0);
        chk("exh_free_lit", 32'(free_slot_count), 32'd0);
        for (int k = 0; k < N; k++) begin
            chk("exh_order_lit", 32'(ready_slot), 32'(k));
            accept();
        end
        rel(2);
        chk("exh_rel_en_lit", 32'(receive_slot_enable), 32'h4);
        chk("exh_rel_free_lit", 32'(free_slot_count), 32'd1);
        rel(0);
        rel(1);
        rel(3);

        // Completion order 2,0,1.
        fill(0, 3); good(0);
        fill(1, 3); good(1);
        accept(); accept();
        fill(2, 3); good(2);
        rel(0); rel(1);
        fill(0, 3); good(0);
        fill(1, 3); good(1);
        chk("ord_a_lit", 32'(ready_slot), 32'd2);
        accept();
        chk("ord_b_lit", 32'(ready_slot), 32'd0);
        accept();
        chk("ord_c_lit", 32'(ready_slot), 32'd1);
        accept();
        rel(2); rel(0); rel(1);

        // Simultaneous good, accept and release on different slots.
        for (int k = 0; k < N; k++) begin
            fill(k, 2);
            good(k);
        end
        repeat (N) accept();
        rel(0);
        fill(0, 2); good(0);
        rel(1);
        fill(1, 3);
        good_packet[1] = 1;
        ready_accept = 1;
        release_valid = 1;
        release_slot = 2'd3;
        step();
        clear_inputs();
        chk("sim_rv_lit", 32'(ready_valid), 32'd1);
        chk("sim_rs_lit", 32'(ready_slot), 32'd1);
        chk("sim_err_lit", 32'(release_error), 32'd0);
        chk("sim_free_lit", 32'(free_slot_count), 32'd1);
        chk("sim_en_lit", 32'(receive_slot_enable), 32'h8);

        // Releasing a READY slot is an error and leaves it offered.
        rel(1);
        chk("err_pulse_lit", 32'(release_error), 32'd1);
        chk("err_rs_lit", 32'(ready_slot), 32'd1);
        step();
        chk("err_clear_lit", 32'(release_error), 32'd0);
        accept();
        rel(0); rel(1); rel(2);

        // Reset mid-packet.
        fill(0, 5);
        packet_data_valid[0] = 1;
        reset_n = 0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_en_lit", 32'(receive_slot_enable), 32'h0);
        chk("rst_gc_lit", 32'(good_packet_count), 32'd0);
        clear_inputs();
        @(negedge clock);
        reset_n = 1;
        step();
        chk("rst_after_en_lit", 32'(receive_slot_enable), 32'h1);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            clear_inputs();
            if (e_en != '0) begin
                if ($urandom_range(0, 99) < 80) packet_data_valid = e_en;
                if ($urandom_range(0, 99) < 12) good_packet = e_en;
                else if ($urandom_range(0, 99) < 6) bad_packet = e_en;
            end
            if ($urandom_range(0, 99) < 5)
                packet_data_valid = packet_data_valid | N'($urandom);
            if ($urandom_range(0, 99) < 4)
                good_packet = good_packet | N'($urandom);
            if ($urandom_range(0, 99) < 4)
                bad_packet = bad_packet | N'($urandom);
            bad_packet = bad_packet & ~good_packet;
            ready_accept = $urandom_range(0, 99) < 40;
            if ($urandom_range(0, 99) < 35) begin
                release_valid = 1;
                serv.delete();
                for (int k = 0; k < N; k++)
                    if (st[k] == S_SERV) serv.push_back(k);
                if (serv.size() > 0 && $urandom_range(0, 99) < 75)
                    release_slot = W'(serv[$urandom_range(0, serv.size() - 1)]);
                else
                    release_slot = W'($urandom_range(0, N - 1));
            end
            step();
        end
        clear_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
